seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
// Parametrised, runtime-configurable serial bit-pattern detector for the FSM experiments.
// Samples serial input x on each enabled clock and pulses z one cycle after the last
// bit of a programmed pattern (1..MAX_LEN bits) arrives.
// Overlapping/non-overlapping mode selectable; saturating hit counter for bench checks.
// PARAMETERS
// MAX_LEN      8          maximum pattern length in bits (>=2)
// LEN_W        4          width of cfg_len; must hold MAX_LEN
// CNT_W        8          width of match_count
// DEF_PATTERN  8'b1011    pattern after reset (LSB = last bit received)
// DEF_LEN      4          pattern length after reset
// PORTS
// clk          in   1        rising-edge clock, single clock domain
// rst          in   1        synchronous, active-high reset
// en           in   1        1: sample x this edge; 0: hold all state
// x            in   1        serial data bit
// cfg_load     in   1        1: latch cfg_* this edge
// cfg_pattern  in   MAX_LEN  pattern; bit 0 = most recent bit, bits >= cfg_len ignored
// cfg_len      in   LEN_W    pattern length
// cfg_overlap  in   1        1: overlapping matches allowed; 0: non-overlapping
// cnt_clr      in   1        1: clear match_count this edge
// z            out  1        registered one-cycle match pulse
// match_count  out  CNT_W    saturating number of matches
// BEHAVIOUR
// - Reset: z=0, match_count=0, hist=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=1.
// - Internal: hist[MAX_LEN-1:0] shift register (newest bit at [0]); fill counter 0..MAX_LEN.
// - Sample edge (en=1, cfg_load=0): nh={hist[MAX_LEN-2:0],x}; nf=min(fill+1,MAX_LEN).
//   hit = (nf>=len) && (nh[len-1:0]==pattern[len-1:0]).
//   hist<=nh; fill<= (hit && !overlap) ? 0 : nf; z<=hit.
// - Latency: z high exactly in the cycle after the edge sampling the final pattern bit.
// - en=0: hist, fill, match_count hold; z<=0 (pulse never stretched).
// - cfg_load=1: pattern/len/overlap latched; hist<=0, fill<=0, z<=0; x that edge discarded
//   even if en=1; match_count kept. Latched len clamped: 0 -> 1, >MAX_LEN -> MAX_LEN.
// - Detection before fill reaches len is forbidden (all-zero pattern must not hit on
//   reset-cleared history).
// - match_count: +1 on hit, saturates at 2^CNT_W-1; cnt_clr=1 wins over same-edge hit
//   (result 0). z still pulses on that hit.
// - rst has priority over cfg_load, cnt_clr and en; rst mid-pattern discards partial
//   history, so a pattern straddling reset is not detected.
// - No combinational path from inputs to outputs.
// TESTING
// 1 Defaults (1011, overlap): x=1,0,1,1,0,1,1 -> z pulses after bits 4 and 7; count=2.
// 2 cfg_overlap=0, same pattern/stream -> single pulse after bit 4; count=1.
// 3 cfg_load pattern=8'b0, len=3; after load x=0,0,0,0 -> z after bits 3 and 4, none earlier.
// 4 len=1 pattern=1, x=1,1,0,1 -> z is x delayed one cycle (1,1,0,1); cfg_len=0 behaves same.
// 5 CNT_W=2, 5 hits -> count 1,2,3,3,3; cnt_clr with 6th hit -> count 0, z=1.
// 6 x=1,0,1 then rst, then x=1 -> no pulse; en=0 gap mid-pattern -> match still found.

Source files
------------

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Runtime-configurable serial bit-pattern detector with overlap
//            control and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1011),
    parameter int                 DEF_LEN     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_def_len = LEN_W'(DEF_LEN);

    // Only the newest MAX_LEN-1 bits are kept: the oldest bit of a full
    // window is shifted out before it could ever be compared again.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_z;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_nh;
    logic [LEN_W-1:0]   w_nf;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_sample;
    logic               w_hit;

    assign w_sample = en & ~cfg_load;
    assign w_nh     = {r_hist, x};
    assign w_nf     = (r_fill >= c_max_len) ? c_max_len : r_fill + LEN_W'(1);

    // Bits at or above the programmed length are excluded from the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign w_mask[gi] = (LEN_W'(gi) < r_len);
    end

    assign w_hit = w_sample && (w_nf >= r_len) &&
                   (((w_nh ^ r_pattern) & w_mask) == '0);

    assign w_len_clamp = (cfg_len == '0)       ? LEN_W'(1) :
                         (cfg_len > c_max_len) ? c_max_len : cfg_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= DEF_PATTERN;
            r_len     <= c_def_len;
            r_overlap <= 1'b1;
            r_z       <= 1'b0;
            r_count   <= '0;
        end else begin
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_len_clamp;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
                r_z       <= 1'b0;
            end else if (en) begin
                r_hist <= w_nh[MAX_LEN-2:0];
                r_fill <= (w_hit && !r_overlap) ? '0 : w_nf;
                r_z    <= w_hit;
            end else begin
                r_z    <= 1'b0;
            end

            if (cnt_clr) begin
                r_count <= '0;
            end else if (w_hit && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign z           = r_z;
    assign match_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Directed self-checking bench for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       x;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       z;
    logic       z2;
    logic [7:0] match_count;
    logic [1:0] mc2;

    int n_cmp = 0;
    int n_err = 0;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .z(z), .match_count(match_count)
    );

    // Narrow-counter instance for saturation checks; shares all stimulus.
    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .z(z2), .match_count(mc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_z(input string tag, input logic exp);
        n_cmp++;
        assert (z === exp) else begin
            n_err++;
            $error("FAIL %s: z observed %b expected %b", tag, z, exp);
        end
    endtask

    task automatic chk_z2(input string tag, input logic exp);
        n_cmp++;
        assert (z2 === exp) else begin
            n_err++;
            $error("FAIL %s: z(cnt2) observed %b expected %b", tag, z2, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (match_count === exp) else begin
            n_err++;
            $error("FAIL %s: match_count observed %0d expected %0d", tag, match_count, exp);
        end
    endtask

    task automatic chk_cnt2(input string tag, input logic [1:0] exp);
        n_cmp++;
        assert (mc2 === exp) else begin
            n_err++;
            $error("FAIL %s: match_count(cnt2) observed %0d expected %0d", tag, mc2, exp);
        end
    endtask

    task automatic step(input logic xv, input logic ev, input logic ez, input string tag);
        x  = xv;
        en = ev;
        tick();
        chk_z(tag, ez);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        en          = 1'b1;
        x           = 1'b1;
        tick();
        cfg_load    = 1'b0;
        chk_z("load_z", 1'b0);
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        en      = 1'b0;
        tick();
        cnt_clr = 1'b0;
        chk_cnt("clr", 8'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b1; cnt_clr = 1'b0;
        tick();
        tick();
        chk_z("rst_z", 1'b0);
        chk_cnt("rst_cnt", 8'd0);
        chk_cnt2("rst_cnt2", 2'd0);
        rst = 1'b0;

        // Defaults 1011, overlapping
        step(1, 1, 0, "t1_b1"); step(0, 1, 0, "t1_b2"); step(1, 1, 0, "t1_b3");
        step(1, 1, 1, "t1_b4"); step(0, 1, 0, "t1_b5"); step(1, 1, 0, "t1_b6");
        step(1, 1, 1, "t1_b7");
        chk_cnt("t1_cnt", 8'd2);

        // Non-overlapping: second pulse suppressed
        load(8'b1011, 4'd4, 1'b0);
        chk_cnt("t2_load_keeps_cnt", 8'd2);
        step(1, 1, 0, "t2_b1"); step(0, 1, 0, "t2_b2"); step(1, 1, 0, "t2_b3");
        step(1, 1, 1, "t2_b4"); step(0, 1, 0, "t2_b5"); step(1, 1, 0, "t2_b6");
        step(1, 1, 0, "t2_b7");
        chk_cnt("t2_cnt", 8'd3);
        clear_cnt();

        // All-zero pattern must wait for the history to fill
        load(8'b0, 4'd3, 1'b1);
        step(0, 1, 0, "t3_b1"); step(0, 1, 0, "t3_b2");
        step(0, 1, 1, "t3_b3"); step(0, 1, 1, "t3_b4");
        chk_cnt("t3_cnt", 8'd2);

        // Length 1: z is x delayed; cfg_len=0 clamps to 1
        load(8'b1, 4'd1, 1'b1);
        step(1, 1, 1, "t4_b1"); step(1, 1, 1, "t4_b2");
        step(0, 1, 0, "t4_b3"); step(1, 1, 1, "t4_b4");
        load(8'b1, 4'd0, 1'b1);
        step(1, 1, 1, "t4z_b1"); step(1, 1, 1, "t4z_b2");
        step(0, 1, 0, "t4z_b3"); step(1, 1, 1, "t4z_b4");
        // Length above MAX_LEN clamps to 8
        load(8'b1010_0101, 4'd9, 1'b0);
        step(1, 1, 0, "t4c_b1"); step(0, 1, 0, "t4c_b2"); step(1, 1, 0, "t4c_b3");
        step(0, 1, 0, "t4c_b4"); step(0, 1, 0, "t4c_b5"); step(1, 1, 0, "t4c_b6");
        step(0, 1, 0, "t4c_b7"); step(1, 1, 1, "t4c_b8");
        chk_cnt("t4_cnt", 8'd9);

        // Saturation on the 2-bit counter, clear wins over hit
        load(8'b1, 4'd1, 1'b1);
        clear_cnt();
        chk_cnt2("t5_clr2", 2'd0);
        step(1, 1, 1, "t5_h1"); chk_cnt2("t5_c1", 2'd1);
        step(1, 1, 1, "t5_h2"); chk_cnt2("t5_c2", 2'd2);
        step(1, 1, 1, "t5_h3"); chk_cnt2("t5_c3", 2'd3);
        step(1, 1, 1, "t5_h4"); chk_cnt2("t5_c4", 2'd3);
        step(1, 1, 1, "t5_h5"); chk_cnt2("t5_c5", 2'd3);
        chk_cnt("t5_cnt8", 8'd5);
        cnt_clr = 1'b1;
        step(1, 1, 1, "t5_h6");
        cnt_clr = 1'b0;
        chk_z2("t5_h6_z2", 1'b1);
        chk_cnt2("t5_c6", 2'd0);
        chk_cnt("t5_c6_8", 8'd0);

        // Reset mid-pattern discards partial history
        load(8'b1011, 4'd4, 1'b1);
        step(1, 1, 0, "t6_b1"); step(0, 1, 0, "t6_b2"); step(1, 1, 0, "t6_b3");
        rst = 1'b1; x = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0;
        chk_z("t6_rst_z", 1'b0);
        chk_cnt("t6_rst_cnt", 8'd0);
        step(1, 1, 0, "t6_after_rst");
        // en=0 gap inside a pattern is transparent
        step(0, 1, 0, "t6_g2");
        step(1, 0, 0, "t6_gap1");
        step(1, 1, 0, "t6_g3");
        step(0, 0, 0, "t6_gap2");
        step(1, 1, 1, "t6_g4");
        step(1, 0, 0, "t6_hold_no_stretch");
        chk_cnt("t6_cnt", 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
